// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester APB master with round-robin arbitration.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// 16 consecutive cycles with pready low (done and err pulse together).
// Without the macro the master waits in ACCESS indefinitely and err is 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   req[1:0]   per-requester request (bit i = requester i)
//   wr[1:0]    per-requester direction, 1 = write
//   addr       per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   done[1:0]  one-cycle completion pulse to the granted requester
//   rdata      read data of the last completed read
//   err        one-cycle pulse with done on an aborted transfer
//   psel, penable, pwrite, paddr, pwdata   registered APB master outputs
//   prdata, pready                         APB slave response
//   dbg_state  current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Requester handshake: a requester raises req[i] with wr/addr/wdata valid and
// holds req[i] until it sees done[i]. The command is captured when the grant
// is issued, so the requester may change wr/addr/wdata afterwards. done[i] is
// the single-cycle acknowledgement; req[i] is ignored in that cycle so a
// requester that drops req on seeing done is never granted twice.
module apb_master_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            wr,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       grant;       // requester owning the current transfer
  logic       last_grant;  // most recently granted requester (lowest priority)
  logic [1:0] eligible;
  logic       any_req;
  logic       next_grant;
  logic       abort;

  assign dbg_state = state;

  // A requester being acknowledged this cycle is not eligible again yet.
  assign eligible = req & ~done;
  assign any_req  = |eligible;

  always_comb begin
    next_grant = 1'b0;
    if (eligible == 2'b11) begin
      next_grant = ~last_grant;
    end else begin
      next_grant = eligible[1];
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [3:0] tcnt;

  // tcnt counts ACCESS cycles with pready low; the 16th such cycle aborts.
  assign abort = (state == ACCESS) && !pready && (tcnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= 4'd0;
      err  <= 1'b0;
    end else begin
      err <= abort;
      if (state == SETUP) begin
        tcnt <= 4'd0;
      end else if ((state == ACCESS) && !pready) begin
        tcnt <= tcnt + 4'd1;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // so requester 0 wins the first contention
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rdata      <= '0;
      done       <= 2'b00;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= SETUP;
            grant      <= next_grant;
            last_grant <= next_grant;
            psel       <= 1'b1;
            penable    <= 1'b0;
            pwrite     <= next_grant ? wr[1] : wr[0];
            paddr      <= next_grant ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            pwdata     <= next_grant ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= grant ? 2'b10 : 2'b01;
            if (!pwrite) begin
              rdata <= prdata;
            end
          end else if (abort) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= grant ? 2'b10 : 2'b01;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester transfer request, bit i = requester i, held until done[i].
REQ-006 SHALL have port wr  input  2  per-requester direction, 1 = write.
REQ-007 SHALL have port addr  input  2*ADDR_W  per-requester address, requester i in slice [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wdata  input  2*DATA_W  per-requester write data, same slicing.
REQ-009 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata  output  DATA_W  read data of the last completed read.
REQ-011 SHALL have port err  output  1  one-cycle pulse coincident with done on an aborted transfer.
REQ-012 SHALL have ports psel, penable, pwrite  output  1 each  APB master controls.
REQ-013 SHALL have ports paddr  output  ADDR_W and pwdata  output  DATA_W  APB address and write data.
REQ-014 SHALL have ports prdata  input  DATA_W and pready  input  1  APB slave response.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-016 SHALL, in IDLE with any eligible req bit set, grant one requester and move to SETUP on the next edge.
REQ-017 SHALL arbitrate round-robin: requester last granted has lowest priority; after reset requester 0 has priority.
REQ-018 SHALL treat req[i] as ineligible in the cycle done[i] is high.
REQ-019 SHALL latch wr, addr, wdata of the granted requester on the IDLE->SETUP edge; later input changes SHALL NOT affect the transfer.
REQ-020 SHALL drive SETUP: psel=1, penable=0, for exactly one cycle, then enter ACCESS.
REQ-021 SHALL drive ACCESS: psel=1, penable=1, paddr/pwrite/pwdata stable, until pready=1 is sampled.
REQ-022 SHALL, on the edge sampling pready=1 in ACCESS, return to IDLE, drop psel/penable, pulse done[grant] for one cycle, and capture prdata into rdata if pwrite=0.
REQ-023 SHALL leave rdata unchanged on write completions and on aborts.
REQ-024 SHALL complete a started transfer even if the requester deasserts req mid-transfer.
REQ-025 SHALL yield minimum latency: req high in IDLE at edge N -> psel at N+1, penable at N+2, done at N+3 with zero wait states.
REQ-026 SHALL spend at least one IDLE cycle between consecutive transfers.
REQ-027 SHALL, with both req bits set simultaneously, alternate grants 0,1,0,1... over consecutive transfers.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rdata=0, done=0, err=0, round-robin pointer favouring requester 0.
REQ-029 SHALL, on rst asserted mid-transfer, abandon the transfer immediately with no done pulse.

Configuration
REQ-030 SHALL, with macro APB_ARB_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0 and, on the 16th such cycle, abort: return to IDLE, drop psel/penable, pulse done[grant] and err together.
REQ-031 SHALL reset the timeout counter on every entry to SETUP.
REQ-032 SHALL, without APB_ARB_TIMEOUT_EN, wait in ACCESS indefinitely and tie err to 0.

Verification
REQ-033 SHALL cover: req=01, wr=0, addr0=0x10, pready=1 immediately, prdata=0xDEADBEEF -> psel at N+1, penable at N+2, done=01 and rdata=0xDEADBEEF at N+3.
REQ-034 SHALL cover: req=10, wr=10, addr1=0x22, wdata1=0x1234, pready low 3 cycles -> ACCESS held 4 cycles, paddr=0x22, pwdata=0x1234 stable, done=10, rdata unchanged.
REQ-035 SHALL cover: req=11 held for 4 transfers, pready=1 -> grants 0,1,0,1, one IDLE cycle between each.
REQ-036 SHALL cover: rst driven low during ACCESS -> psel=penable=0 within the same cycle, no done pulse, next grant to requester 0.
REQ-037 SHALL cover with APB_ARB_TIMEOUT_EN: pready held 0 -> done and err pulse after the 16th ACCESS cycle, psel=0 next cycle; without macro, psel remains high for 100 cycles and err stays 0.
